// File: rtl/branch_unit_pkg.sv
// Shared CPU parameters for branch resolution: op encodings, BHT reset value, delay-slot offset.
package branch_unit_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NONE = 3'd0,
    OP_BEQ  = 3'd1,
    OP_BNE  = 3'd2,
    OP_BGEZ = 3'd3,
    OP_BGTZ = 3'd4,
    OP_BLEZ = 3'd5,
    OP_BLTZ = 3'd6,
    OP_RSVD = 3'd7
  } br_op_e;

  localparam logic [1:0]      BHT_RESET_VAL     = 2'b01;
  localparam logic [PC_W-1:0] DELAY_SLOT_OFFSET = 32'd8;

  // Ops 1..6 are real branches; none and reserved never commit.
  function automatic logic is_branch_op(input logic [OP_W-1:0] op);
    return (op != OP_NONE) && (op != OP_RSVD);
  endfunction

endpackage

// File: rtl/branch_unit_cmp.sv
// Branch condition evaluation: equality and signed compare-against-zero.
module branch_cmp
  import branch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             taken
);

  logic a_neg;
  logic a_zero;

  assign a_neg  = a[WIDTH-1];
  assign a_zero = (a == '0);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = (a == b);
      OP_BNE:  taken = (a != b);
      OP_BGEZ: taken = ~a_neg;
      OP_BGTZ: taken = ~a_neg & ~a_zero;
      OP_BLEZ: taken = a_neg | a_zero;
      OP_BLTZ: taken = a_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution with a flop-based 2-bit BHT predictor and saturating statistics counters.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned BHT_BITS = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              res_valid,
  input  logic              res_stall,
  input  logic [OP_W-1:0]   res_op,
  input  logic [WIDTH-1:0]  res_a,
  input  logic [WIDTH-1:0]  res_b,
  input  logic [PC_W-1:0]   res_pc,
  input  logic [PC_W-1:0]   res_target,
  input  logic              res_pred,
  output logic              res_taken,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned BHT_ENTRIES = 32'd1 << BHT_BITS;

  logic [1:0]          bht [BHT_ENTRIES];
  logic [BHT_BITS-1:0] if_idx;
  logic [BHT_BITS-1:0] res_idx;
  logic [1:0]          res_ctr;
  logic [1:0]          res_ctr_next;
  logic                commit;
  logic                unused_if_pc;

  branch_cmp #(.WIDTH(WIDTH)) u_cmp (
    .op    (res_op),
    .a     (res_a),
    .b     (res_b),
    .taken (res_taken)
  );

  assign if_idx       = if_pc[BHT_BITS+1:2];
  assign res_idx      = res_pc[BHT_BITS+1:2];
  assign unused_if_pc = ^{if_pc[PC_W-1:BHT_BITS+2], if_pc[1:0]};

  assign commit      = res_valid & ~res_stall & is_branch_op(res_op);
  assign mispredict  = commit & (res_taken != res_pred);
  assign redirect_pc = res_taken ? res_target : res_pc + DELAY_SLOT_OFFSET;

  // Lookup reads the stored value; a same-cycle update is only visible next cycle.
  assign if_pred_taken = bht[if_idx][1] & ~reset;
  assign res_ctr       = bht[res_idx];

  // 2-bit saturating counter step.
  always_comb begin
    res_ctr_next = res_ctr;
    if (res_taken) begin
      if (res_ctr != 2'b11) res_ctr_next = res_ctr + 2'd1;
    end else begin
      if (res_ctr != 2'b00) res_ctr_next = res_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht[i] <= BHT_RESET_VAL;
    end else if (commit) begin
      bht[res_idx] <= res_ctr_next;
    end
  end

  // Statistics counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      if (commit && (branch_cnt != '1))   branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict && (miss_cnt != '1)) miss_cnt   <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter BHT_BITS, default 6, log2 of the branch-history-table entry count (64 entries).
REQ-003 SHALL have ports: clk  in  1  rising-edge clock.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: if_pc  in  32  fetch-stage PC for lookup.
REQ-006 SHALL have ports: if_pred_taken  out  1  prediction for if_pc.
REQ-007 SHALL have ports: res_valid  in  1  resolve request valid.
REQ-008 SHALL have ports: res_stall  in  1  pipeline stall; when high, the request SHALL not commit.
REQ-009 SHALL have ports: res_op  in  3  branch op (0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 blez, 6 bltz, 7 reserved).
REQ-010 SHALL have ports: res_a, res_b  in  WIDTH  compare operands.
REQ-011 SHALL have ports: res_pc  in  32  PC of branch; res_target  in  32  taken target; res_pred  in  1  prediction carried from fetch.
REQ-012 SHALL have ports: res_taken  out  1; mispredict  out  1; redirect_pc  out  32.
REQ-013 SHALL have ports: branch_cnt, miss_cnt  out  32  statistics counters.

Function
REQ-014 SHALL compute res_taken combinationally: beq a==b; bne a!=b; bgez/bgtz/blez/bltz compare signed a against zero; ops 0 and 7 give 0.
REQ-015 SHALL index the BHT with pc[BHT_BITS+1:2]; each entry SHALL be a 2-bit saturating counter.
REQ-016 SHALL drive if_pred_taken = MSB of the indexed entry, combinational, with no bypass of a same-cycle update (old value returned).
REQ-017 SHALL define commit = res_valid & !res_stall & (res_op in 1..6).
REQ-018 On commit, the entry for res_pc SHALL update at the next clk edge: taken increments and saturates at 3; not-taken decrements and saturates at 0.
REQ-019 SHALL drive mispredict = commit & (res_taken != res_pred), combinational.
REQ-020 SHALL drive redirect_pc = res_taken ? res_target : res_pc+8 (delay slot), valid only while mispredict is high.
REQ-021 On commit, branch_cnt SHALL increment; on mispredict, miss_cnt SHALL increment; both SHALL saturate at 32'hFFFFFFFF.
REQ-022 SHALL make no state change while res_stall is high, regardless of res_valid.
REQ-023 SHALL return the post-update value for a lookup at the same index one cycle after the update.

Reset
REQ-024 Reset SHALL asynchronously set every BHT entry to 2'b01 (weakly not-taken), branch_cnt=0 and miss_cnt=0.
REQ-025 Reset asserted mid-update SHALL discard the pending update; no entry SHALL hold a value other than 01 after reset deasserts.
REQ-026 During reset, if_pred_taken SHALL be 0; res_taken and redirect_pc SHALL remain combinational functions of their inputs.

Structure
REQ-027 The op encodings, counter reset value (2'b01) and delay-slot offset (8) SHALL live in the shared CPU parameter package.
REQ-028 The comparison logic SHALL be one sub-module, branch_cmp (pure combinational, parameter WIDTH); the BHT and counters stay in branch_unit.
REQ-029 The BHT SHALL be flop-based (1<<BHT_BITS x 2 bits) so that reset clears it asynchronously.

Verification
REQ-030 Signed compare: op=bltz, a=32'hFFFFFFFF -> res_taken=1; op=bgez, a=32'h80000000 -> 0; op=bgtz, a=0 -> 0; op=blez, a=0 -> 1.
REQ-031 Saturation: three taken commits at pc=0x3000 -> entry 01->10->11->11; if_pred_taken=1 from the cycle after the first commit.
REQ-032 Mispredict: res_pred=0, beq a=b=5, res_target=0x3100, res_pc=0x3000 -> mispredict=1, redirect_pc=0x3100, miss_cnt+1; res_pred=1, bne a=b -> mispredict=1, redirect_pc=0x3008.
REQ-033 Stall: res_valid=1, res_stall=1 for 4 cycles, taken -> BHT entry and both counters unchanged.
REQ-034 Aliasing/bypass: update of pc=0x3000 while if_pc=0x3100 (same index when BHT_BITS=6) -> same cycle returns the old value, next cycle returns the new value.
REQ-035 Reset mid-run: after 10 commits, assert reset asynchronously between edges -> counters 0 and all entries 01 immediately; rerun with BHT_BITS=4 and WIDTH=16.
